// File: rtl/ay_seq_pkg.sv
// Shared types and constants for the AY bus sequencer and its request FIFO.
package ay_seq_pkg;

    localparam int unsigned NUM_AY        = 2;
    localparam int unsigned AY_REG_W      = 4;
    localparam int unsigned AY_DATA_W     = 8;
    localparam int unsigned ENTRY_W       = 1 + AY_REG_W + AY_DATA_W;
    localparam logic [6:0]  AY_SEL_PREFIX = 7'h7F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_ADDR,
        ST_DATA,
        ST_RSEL,
        ST_RADDR0,
        ST_RSEL1,
        ST_RADDR1,
        ST_RCHIP
    } seq_state_e;

    typedef struct packed {
        logic                 chip;
        logic [AY_REG_W-1:0]  regn;
        logic [AY_DATA_W-1:0] data;
    } ay_entry_t;

    // Chip-select byte understood by the turbosound block.
    function automatic logic [AY_DATA_W-1:0] sel_byte(input logic chip);
        return {AY_SEL_PREFIX, chip};
    endfunction

endpackage

// File: rtl/ay_seq_fifo.sv
// Synchronous request FIFO with occupancy, full and sticky overflow flags.
module ay_seq_fifo
    import ay_seq_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_i,
    input  ay_entry_t        wr_data_i,
    input  logic             rd_i,
    input  logic             flush_i,
    output ay_entry_t        rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [FIFO_AW:0] level_o,
    output logic             ovf_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   count_q;
    logic               ovf_q;
    logic               do_rd_c, do_wr_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == LVL_W'(DEPTH));
    assign level_o   = count_q;
    assign ovf_o     = ovf_q;
    assign rd_data_o = ay_entry_t'(mem_q[rd_ptr_q]);

    // A pop on the same cycle frees the slot a write into a full queue needs.
    assign do_rd_c = rd_i && !empty_o;
    assign do_wr_c = wr_i && (!full_o || do_rd_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_wr_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (do_rd_c) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q <= count_q + LVL_W'(do_wr_c) - LVL_W'(do_rd_c);
            if (wr_i && !do_wr_c) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr_c) mem_q[wr_ptr_q] <= ENTRY_W'(wr_data_i);
    end

endmodule

// File: rtl/ay_bus_sequencer.sv
// AY bus scheduler: CPU pass-through with priority, queued background register writes
// and shadow-based latch restore. Define AY_SEQ_BATCH_EN to merge same-chip writes.
module ay_bus_sequencer
    import ay_seq_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk35en,
    input  logic                 cpu_bdir,
    input  logic                 cpu_bc1,
    input  logic [AY_DATA_W-1:0] cpu_din,
    input  logic                 rq_wr,
    input  logic                 rq_chip,
    input  logic [AY_REG_W-1:0]  rq_reg,
    input  logic [AY_DATA_W-1:0] rq_data,
    input  logic                 rq_flush,
    output logic                 rq_full,
    output logic [FIFO_AW:0]     rq_level,
    output logic                 rq_ovf,
    output logic                 busy,
    output logic                 ay_bdir,
    output logic                 ay_bc1,
    output logic [AY_DATA_W-1:0] ay_dout
);

    seq_state_e                       state_q, state_d;
    ay_entry_t                        hold_q, hold_d;
    ay_entry_t                        rq_entry, fifo_head;
    logic                             gap_q, gap_d;
    logic                             sh_chip_q, sh_chip_d;
    logic [NUM_AY-1:0][AY_DATA_W-1:0] sh_reg_q, sh_reg_d;
    logic                             bdir_q, bdir_d, bc1_q, bc1_d;
    logic [AY_DATA_W-1:0]             dout_q, dout_d;
    logic                             cpu_act_c, cpu_latch_c, slot_c, pop_c;
    logic                             fifo_empty;

    assign rq_entry = '{chip: rq_chip, regn: rq_reg, data: rq_data};

    ay_seq_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_i      (rq_wr),
        .wr_data_i (rq_entry),
        .rd_i      (pop_c),
        .flush_i   (rq_flush),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (rq_full),
        .level_o   (rq_level),
        .ovf_o     (rq_ovf)
    );

    assign cpu_act_c   = cpu_bdir | cpu_bc1;
    assign cpu_latch_c = cpu_bdir & cpu_bc1;
    assign slot_c      = clk35en & ~cpu_act_c;

    assign busy    = (state_q != ST_IDLE);
    assign ay_bdir = bdir_q;
    assign ay_bc1  = bc1_q;
    assign ay_dout = dout_q;

    // Next state, shadow tracking and next bus drive.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        sh_chip_d = sh_chip_q;
        sh_reg_d  = sh_reg_q;
        pop_c     = 1'b0;
        bdir_d    = 1'b0;
        bc1_d     = 1'b0;
        dout_d    = dout_q;

        if (cpu_act_c) begin
            bdir_d = cpu_bdir;
            bc1_d  = cpu_bc1;
            dout_d = cpu_din;
            if (cpu_latch_c) begin
                if (cpu_din[7:1] == AY_SEL_PREFIX) sh_chip_d = cpu_din[0];
                else                               sh_reg_d[sh_chip_q] = cpu_din;
                // The CPU moved the AY latch under us; replay the held entry.
                if (state_q != ST_IDLE) state_d = ST_SEL;
            end
        end else if (slot_c && gap_q) begin
            gap_d = 1'b0;
        end else if (slot_c) begin
            if (state_q != ST_IDLE) begin
                bdir_d = 1'b1;
                bc1_d  = 1'b1;
                gap_d  = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        hold_d  = fifo_head;
                        state_d = ST_SEL;
                    end
                end
                ST_SEL: begin
                    dout_d  = sel_byte(hold_q.chip);
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    dout_d  = {4'h0, hold_q.regn};
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    bc1_d  = 1'b0;
                    dout_d = hold_q.data;
`ifdef AY_SEQ_BATCH_EN
                    if (!fifo_empty && (fifo_head.chip == hold_q.chip)) begin
                        pop_c   = 1'b1;
                        hold_d  = fifo_head;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_RSEL;
                    end
`else
                    state_d = ST_RSEL;
`endif
                end
                ST_RSEL: begin
                    dout_d  = sel_byte(1'b0);
                    state_d = ST_RADDR0;
                end
                ST_RADDR0: begin
                    dout_d  = sh_reg_q[0];
                    state_d = ST_RSEL1;
                end
                ST_RSEL1: begin
                    dout_d  = sel_byte(1'b1);
                    state_d = ST_RADDR1;
                end
                ST_RADDR1: begin
                    dout_d  = sh_reg_q[1];
                    state_d = ST_RCHIP;
                end
                ST_RCHIP: begin
                    dout_d  = sel_byte(sh_chip_q);
                    state_d = ST_IDLE;
                end
                default: begin
                    bdir_d  = 1'b0;
                    bc1_d   = 1'b0;
                    gap_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            gap_q     <= 1'b0;
            sh_chip_q <= 1'b1;
            sh_reg_q  <= '0;
            bdir_q    <= 1'b0;
            bc1_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            sh_chip_q <= sh_chip_d;
            sh_reg_q  <= sh_reg_d;
            bdir_q    <= bdir_d;
            bc1_q     <= bc1_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Directed bench for ay_bus_sequencer; define AY_SEQ_BATCH_EN for both files to
// expect the merged same-chip sequence.
`timescale 1ns/1ps
module tb_ay_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk35en;
    logic       cpu_bdir, cpu_bc1;
    logic [7:0] cpu_din;
    logic       rq_wr, rq_chip;
    logic [3:0] rq_reg;
    logic [7:0] rq_data;
    logic       rq_flush;
    logic       rq_full;
    logic [4:0] rq_level;
    logic       rq_ovf, busy;
    logic       ay_bdir, ay_bc1;
    logic [7:0] ay_dout;

    int checks = 0;
    int errors = 0;
    int div    = 1;

    logic [8:0] got[$];
    int         gap_viol;

    ay_bus_sequencer #(.FIFO_AW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk35en  (clk35en),
        .cpu_bdir (cpu_bdir),
        .cpu_bc1  (cpu_bc1),
        .cpu_din  (cpu_din),
        .rq_wr    (rq_wr),
        .rq_chip  (rq_chip),
        .rq_reg   (rq_reg),
        .rq_data  (rq_data),
        .rq_flush (rq_flush),
        .rq_full  (rq_full),
        .rq_level (rq_level),
        .rq_ovf   (rq_ovf),
        .busy     (busy),
        .ay_bdir  (ay_bdir),
        .ay_bc1   (ay_bc1),
        .ay_dout  (ay_dout)
    );

    always #5 clk = ~clk;

    // Slot enable: one clk in every 'div'.
    initial begin
        int cnt;
        cnt = 0;
        clk35en = 1'b1;
        forever begin
            @(negedge clk);
            clk35en = (cnt == 0);
            cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
        end
    end

    task automatic do_reset();
        reset_n  = 1'b0;
        cpu_bdir = 1'b0;
        cpu_bc1  = 1'b0;
        cpu_din  = 8'h00;
        rq_wr    = 1'b0;
        rq_chip  = 1'b0;
        rq_reg   = 4'h0;
        rq_data  = 8'h00;
        rq_flush = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic chip, input logic [3:0] r, input logic [7:0] d);
        rq_chip = chip;
        rq_reg  = r;
        rq_data = d;
        rq_wr   = 1'b1;
        @(negedge clk);
        rq_wr   = 1'b0;
    endtask

    // Record every cycle the AY sees bdir=1 as {bc1, dout}; counts back-to-back drives.
    task automatic collect(input int n);
        int   cyc;
        logic prev;
        cyc = 0;
        prev = 1'b0;
        got.delete();
        gap_viol = 0;
        while (got.size() < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (ay_bdir) begin
                got.push_back({ay_bc1, ay_dout});
                if (prev) gap_viol++;
            end
            prev = ay_bdir;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ay_bdir !== 1'b0)   begin errors++; $display("FAIL reset_bdir: got %b, expected 0", ay_bdir); end
        checks++; if (ay_bc1 !== 1'b0)    begin errors++; $display("FAIL reset_bc1: got %b, expected 0", ay_bc1); end
        checks++; if (ay_dout !== 8'h00)  begin errors++; $display("FAIL reset_dout: got %h, expected 00", ay_dout); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (rq_level !== 5'd0)  begin errors++; $display("FAIL reset_level: got %0d, expected 0", rq_level); end
        checks++; if (rq_full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b, expected 0", rq_full); end
        checks++; if (rq_ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b, expected 0", rq_ovf); end
    endtask

    task automatic test_single_write();
        logic [8:0] exp[$];
        do_reset();
        div = 3;
        push(1'b1, 4'd7, 8'h38);
        collect(8);
        exp = '{9'h1FF, 9'h107, 9'h038, 9'h1FE, 9'h100, 9'h1FF, 9'h100, 9'h1FF};
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL single_count: got %0d drives, expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'bx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL single_seq[%0d]: got bc1/dout %h, expected %h", i, g, exp[i]); end
        end
        checks++; if (gap_viol != 0) begin errors++; $display("FAIL single_gap: got %0d back-to-back drives, expected 0", gap_viol); end
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
        checks++; if (ay_bdir !== 1'b0) begin errors++; $display("FAIL single_bus_idle: got bdir %b, expected 0", ay_bdir); end
        div = 1;
    endtask

    task automatic test_shadow_restore();
        logic [8:0] exp[$];
        do_reset();
        cpu_bdir = 1'b1; cpu_bc1 = 1'b1; cpu_din = 8'hFE;
        @(negedge clk);
        checks++;
        if ({ay_bdir, ay_bc1, ay_dout} !== {2'b11, 8'hFE}) begin
            errors++; $display("FAIL cpu_pass_sel: got %b%b %h, expected 11 fe", ay_bdir, ay_bc1, ay_dout);
        end
        cpu_din = 8'h0B;
        @(negedge clk);
        checks++;
        if ({ay_bdir, ay_bc1, ay_dout} !== {2'b11, 8'h0B}) begin
            errors++; $display("FAIL cpu_pass_reg: got %b%b %h, expected 11 0b", ay_bdir, ay_bc1, ay_dout);
        end
        cpu_bdir = 1'b0; cpu_bc1 = 1'b0;
        push(1'b1, 4'd2, 8'h55);
        collect(8);
        exp = '{9'h1FF, 9'h102, 9'h055, 9'h1FE, 9'h10B, 9'h1FF, 9'h100, 9'h1FE};
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL shadow_count: got %0d drives, expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'bx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL shadow_seq[%0d]: got bc1/dout %h, expected %h", i, g, exp[i]); end
        end
        checks++; if (gap_viol != 0) begin errors++; $display("FAIL shadow_gap: got %0d back-to-back drives, expected 0", gap_viol); end
    endtask

    task automatic test_restart();
        logic [8:0] exp[$];
        do_reset();
        push(1'b1, 4'd2, 8'h55);
        collect(2);
        checks++;
        if (got.size() != 2 || got[0] !== 9'h1FF || got[1] !== 9'h102) begin
            errors++; $display("FAIL restart_prefix: got %0d drives, expected sel ff then addr 02", got.size());
        end
        cpu_bdir = 1'b1; cpu_bc1 = 1'b1; cpu_din = 8'h05;
        @(negedge clk);
        cpu_bdir = 1'b0; cpu_bc1 = 1'b0;
        collect(8);
        exp = '{9'h1FF, 9'h102, 9'h055, 9'h1FE, 9'h100, 9'h1FF, 9'h105, 9'h1FF};
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL restart_count: got %0d drives, expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'bx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL restart_seq[%0d]: got bc1/dout %h, expected %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_fifo_overflow();
        logic [8:0] exp[$];
        do_reset();
        cpu_bc1 = 1'b1;
        for (int i = 0; i < 17; i++) push(1'b1, 4'(i), 8'(i));
        checks++; if (rq_full !== 1'b1)   begin errors++; $display("FAIL ovf_full: got %b, expected 1", rq_full); end
        checks++; if (rq_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d, expected 16", rq_level); end
        checks++; if (rq_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_flag: got %b, expected 1", rq_ovf); end
        rq_flush = 1'b1;
        @(negedge clk);
        rq_flush = 1'b0;
        checks++; if (rq_level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d, expected 0", rq_level); end
        checks++; if (rq_ovf !== 1'b0)   begin errors++; $display("FAIL flush_ovf: got %b, expected 0", rq_ovf); end

        for (int i = 0; i < 16; i++) push(1'b0, 4'(i + 3), 8'(8'hA0 + i));
        checks++; if (rq_ovf !== 1'b0) begin errors++; $display("FAIL fill16_ovf: got %b, expected 0", rq_ovf); end
        // Release the bus for exactly one slot: the pop and a write into the full queue coincide.
        cpu_bc1 = 1'b0;
        rq_chip = 1'b1; rq_reg = 4'hF; rq_data = 8'hEE; rq_wr = 1'b1;
        @(negedge clk);
        rq_wr = 1'b0;
        cpu_bc1 = 1'b1;
        checks++; if (rq_level !== 5'd16) begin errors++; $display("FAIL popwr_level: got %0d, expected 16", rq_level); end
        checks++; if (rq_ovf !== 1'b0)    begin errors++; $display("FAIL popwr_ovf: got %b, expected 0", rq_ovf); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL popwr_busy: got %b, expected 1", busy); end
        rq_flush = 1'b1;
        @(negedge clk);
        rq_flush = 1'b0;
        cpu_bc1 = 1'b0;
        collect(8);
        exp = '{9'h1FE, 9'h103, 9'h0A0, 9'h1FE, 9'h100, 9'h1FF, 9'h100, 9'h1FF};
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL inflight_count: got %0d drives, expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'bx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL inflight_seq[%0d]: got bc1/dout %h, expected %h", i, g, exp[i]); end
        end
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inflight_busy_end: got %b, expected 0", busy); end
    endtask

    task automatic test_reset_mid_sequence();
        bit found;
        int drives;
        do_reset();
        push(1'b0, 4'd9, 8'h77);
        push(1'b1, 4'd4, 8'h88);
        collect(2);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (ay_bdir && !ay_bc1) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_mid_data_seen: got no data drive, expected one"); end
        reset_n = 1'b0;
        #1;
        checks++; if (ay_bdir !== 1'b0)  begin errors++; $display("FAIL rst_mid_bdir: got %b, expected 0", ay_bdir); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
        checks++; if (rq_level !== 5'd0) begin errors++; $display("FAIL rst_mid_level: got %0d, expected 0", rq_level); end
        @(negedge clk);
        reset_n = 1'b1;
        drives = 0;
        repeat (12) begin
            @(negedge clk);
            if (ay_bdir) drives++;
        end
        checks++; if (drives != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d drives after reset, expected 0", drives); end
    endtask

    task automatic test_batch();
        logic [8:0] exp[$];
        do_reset();
        cpu_bc1 = 1'b1;
        push(1'b0, 4'd1, 8'h11);
        push(1'b0, 4'd2, 8'h22);
        push(1'b0, 4'd3, 8'h33);
        cpu_bc1 = 1'b0;
`ifdef AY_SEQ_BATCH_EN
        exp = '{9'h1FE, 9'h101, 9'h011, 9'h102, 9'h022, 9'h103, 9'h033,
                9'h1FE, 9'h100, 9'h1FF, 9'h100, 9'h1FF};
`else
        exp.delete();
        for (int r = 1; r <= 3; r++) begin
            exp.push_back(9'h1FE);
            exp.push_back({1'b1, 4'h0, 4'(r)});
            exp.push_back({1'b0, 8'(r * 17)});
            exp.push_back(9'h1FE);
            exp.push_back(9'h100);
            exp.push_back(9'h1FF);
            exp.push_back(9'h100);
            exp.push_back(9'h1FF);
        end
`endif
        collect(exp.size());
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL batch_count: got %0d drives, expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'bx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL batch_seq[%0d]: got bc1/dout %h, expected %h", i, g, exp[i]); end
        end
        checks++; if (gap_viol != 0) begin errors++; $display("FAIL batch_gap: got %0d back-to-back drives, expected 0", gap_viol); end
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL batch_busy_end: got %b, expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_shadow_restore();
        test_restart();
        test_fifo_overflow();
        test_reset_mid_sequence();
        test_batch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ay_bus_sequencer.md
Name: ay_bus_sequencer

Overview:
- Bus-cycle scheduler in front of the turbosound block: shares the AY bus (bdir/bc1/din) between the Z80 and a background register-write requester (hardware music player / DMA).
- Queues requester writes in a FIFO and emits select / address / data bus sequences only in slots the CPU leaves free.
- Shadows the CPU's selected chip and latched register, and restores them after every sequence, so CPU software never sees the interference.

Parameters:
- FIFO_AW, 4, log2 of queue depth (16 entries).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clk35en  in  1  3.5 MHz slot enable; the sequencer advances only on cycles where it is 1
- cpu_bdir  in  1  CPU-decoded AY bdir
- cpu_bc1  in  1  CPU-decoded AY bc1
- cpu_din  in  8  CPU data bus
- rq_wr  in  1  requester write strobe, one clk pulse per entry
- rq_chip  in  1  target chip: 1 = first AY, 0 = second AY (same encoding as select value bit 0)
- rq_reg  in  4  AY register number
- rq_data  in  8  register value
- rq_flush  in  1  synchronous FIFO clear
- rq_full  out  1  FIFO full
- rq_level  out  FIFO_AW+1  entries queued
- rq_ovf  out  1  sticky overflow; cleared by reset or rq_flush
- busy  out  1  sequencer not in IDLE
- ay_bdir  out  1  to turbosound bdir
- ay_bc1  out  1  to turbosound bc1
- ay_dout  out  8  to turbosound din

Behaviour:
- Reset values:
  - FIFO empty; rq_ovf = 0.
  - FSM in IDLE.
  - ay_bdir = ay_bc1 = 0; ay_dout = 8'h00.
  - Shadow: sh_chip = 1; sh_reg[0] = sh_reg[1] = 8'h00.
- Reset mid-sequence aborts immediately. The AY sees no further cycles.
- Outputs are registered: one clk of latency from cpu_* and from the internal drive.
- CPU priority:
  - Any cycle with cpu_bdir|cpu_bc1 = 1 passes the cpu_* signals straight to ay_*.
  - The sequencer holds its state that cycle and drives nothing.
  - CPU activity always wins, including on the same cycle as a sequencer drive slot.
- Shadow tracking, on CPU cycles with bdir = 1 and bc1 = 1:
  - If cpu_din[7:1] = 7'h7F: sh_chip <= cpu_din[0].
  - Otherwise: sh_reg[sh_chip] <= cpu_din.
  - If the CPU address-latches during a sequence, the sequence restarts at SEL. The popped entry is retained.
- Sequencer drive slot:
  - One clk where clk35en = 1 and the CPU is idle.
  - Each drive slot is followed by at least one gap slot with bdir = bc1 = 0.
- FSM states and slot content:
  - IDLE: no drive. If FIFO is non-empty, pop the entry into a holding register and go to SEL.
  - SEL: bdir = 1, bc1 = 1, dout = {7'h7F, chip}.
  - ADDR: bdir = 1, bc1 = 1, dout = {4'h0, reg}.
  - DATA: bdir = 1, bc1 = 0, dout = data.
  - RSEL: bdir = 1, bc1 = 1, dout = {7'h7F, 1'b0}. Restores the second AY's latched register.
  - RADDR0: bdir = 1, bc1 = 1, dout = sh_reg[0].
  - RSEL1: bdir = 1, bc1 = 1, dout = {7'h7F, 1'b1}.
  - RADDR1: bdir = 1, bc1 = 1, dout = sh_reg[1].
  - RCHIP: bdir = 1, bc1 = 1, dout = {7'h7F, sh_chip}. Then back to IDLE.
- Restore order is fixed: second AY, then first AY, then the CPU's chip.
- Every state's output persists for exactly one drive slot.
- FIFO:
  - rq_wr while full: entry dropped, rq_ovf <= 1.
  - rq_wr on a cycle where a pop occurs and the FIFO is full: accepted.
  - rq_flush empties the queue, clears rq_ovf, and does not abort the in-flight entry.
  - Pointers wrap modulo 2^FIFO_AW; rq_level saturates at 2^FIFO_AW.

Optional Feature:
- Macro: AY_SEQ_BATCH_EN.
- Defined: after DATA, if the FIFO head targets the same chip, pop it and go directly to ADDR (skip SEL and restore). Restore runs once, when the queue empties or the chip changes.
- Undefined: every entry runs the full SEL..RCHIP sequence.

Decomposition:
- Shared package ay_seq_pkg:
  - State enum.
  - Constants: AY_SEL_PREFIX = 7'h7F, NUM_AY = 2.
  - Entry width: 13 (chip + reg + data).
- Sub-module: ay_seq_fifo, a synchronous FIFO with level, full and overflow flags.

Test Plan:
- After reset, rq_wr chip = 1, reg = 7, data = 8'h38, CPU idle. Bus must show, one drive slot each with gaps between:
  - 8'hFF (bdir = 1, bc1 = 1)
  - 8'h07 (bdir = 1, bc1 = 1)
  - 8'h38 (bdir = 1, bc1 = 0)
  - 8'hFE, 8'h00, 8'hFF, 8'h00, 8'hFF (all bdir = 1, bc1 = 1)
  - then busy = 0.
- CPU writes latch 8'hFE, then latch 8'h0B; queue chip = 1, reg = 2, data = 8'h55. Restore must emit 8'h0B for the second AY and end with 8'hFE.
- CPU latch 8'h05 lands between ADDR and DATA. The sequence must restart at SEL, and data 8'h55 must be written only after a fresh ADDR 8'h02.
- 17 rq_wr with no pops (CPU holds the bus): rq_full = 1, rq_level = 16, rq_ovf = 1. rq_flush then gives level 0 and ovf 0.
- Assert reset_n low during DATA: ay_bdir = 0 immediately, busy = 0, FIFO empty.
- AY_SEQ_BATCH_EN defined, three writes to chip 0: expect one SEL, three ADDR/DATA pairs, then a single restore.
